// File: rtl/mul_arbiter_pkg.sv
// Shared constants and helpers for the multiplier arbiter.
// Optional build macro: MUL_ARBITER_HI_EN (exposes the upper product half).
package mul_arbiter_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_N_REQ     = 4;
    localparam int DEF_MUL_LEVEL = 3;

    // Issue-to-response latency: one operand register plus the product stages.
    function automatic int lat_of(input int mul_level);
        return mul_level + 1;
    endfunction

    // Requester id width, never narrower than one bit.
    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/generic_mul.sv
// Pipelined unsigned multiplier: operand register followed by LEVEL product
// registers. PW selects how many product bits are kept, so an unused upper
// half is never built. The data path carries no reset.
module generic_mul #(
    parameter int WIDTH = 32,
    parameter int LEVEL = 3,
    parameter int PW    = 64
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [PW-1:0]    p
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]    p_q [LEVEL];

    // Operand capture, multiply, then shift the product down the pipeline.
    always_ff @(posedge clk) begin
        a_q    <= a;
        b_q    <= b;
        p_q[0] <= PW'(a_q) * PW'(b_q);
        for (int i = 1; i < LEVEL; i++) begin
            p_q[i] <= p_q[i-1];
        end
    end

    assign p = p_q[LEVEL-1];

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: first asserted request scanning from ptr upward
// with wrap-around. Produces a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx
);

    logic found;

    // Rotating priority scan starting at ptr.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one pipelined multiplier among N_REQ requesters. Round-robin issue,
// one outstanding multiply per requester, results returned as a one-cycle
// pulse to the owner. Optional macro MUL_ARBITER_HI_EN adds resp_hi.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int MUL_LEVEL = DEF_MUL_LEVEL,
    parameter int WIDTH     = DEF_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]       resp_data,
`ifdef MUL_ARBITER_HI_EN
    output logic [WIDTH-1:0]       resp_hi,
`endif
    output logic [N_REQ-1:0]       busy
);

    localparam int LAT = lat_of(MUL_LEVEL);
    localparam int IDW = id_w(N_REQ);
`ifdef MUL_ARBITER_HI_EN
    localparam int PW = 2 * WIDTH;
`else
    localparam int PW = WIDTH;
`endif

    logic [IDW-1:0]   ptr;
    logic [N_REQ-1:0] elig;
    logic [IDW-1:0]   gnt_idx;
    logic             issue;
    logic [IDW-1:0]   next_ptr;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [PW-1:0]    prod;
    logic [LAT-1:0]   tag_vld;
    logic [IDW-1:0]   tag_id [LAT];
    logic [IDW-1:0]   resp_id;

    // A requester whose response is firing is still busy, hence ineligible.
    assign elig  = req_valid & ~busy;
    assign issue = |req_ready;

    rr_arbiter #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_arb (
        .req   (elig),
        .ptr   (ptr),
        .grant (req_ready),
        .idx   (gnt_idx)
    );

    assign next_ptr = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // Operand mux; idle cycles feed zeros into the multiplier.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (issue) begin
            mul_a = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
            mul_b = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
        end
    end

    generic_mul #(
        .WIDTH (WIDTH),
        .LEVEL (MUL_LEVEL),
        .PW    (PW)
    ) u_mul (
        .clk (clk),
        .a   (mul_a),
        .b   (mul_b),
        .p   (prod)
    );

    // Tag valid bits track issues in step with the multiplier; reset drops them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_vld <= '0;
        end else begin
            tag_vld <= {tag_vld[LAT-2:0], issue};
        end
    end

    // Tag ids ride alongside the valid bits; only meaningful where valid.
    always_ff @(posedge clk) begin
        tag_id[0] <= gnt_idx;
        for (int i = 1; i < LAT; i++) begin
            tag_id[i] <= tag_id[i-1];
        end
    end

    // Pointer advances past each grant; busy sets on grant, clears on response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr  <= '0;
            busy <= '0;
        end else begin
            busy <= (busy | req_ready) & ~resp_valid;
            if (issue) begin
                ptr <= next_ptr;
            end
        end
    end

    assign resp_id = tag_id[LAT-1];

    // Response pulse decoded straight from the last tag stage.
    always_comb begin
        resp_valid = '0;
        if (tag_vld[LAT-1]) begin
            resp_valid[resp_id] = 1'b1;
        end
    end

    assign resp_data = prod[WIDTH-1:0];
`ifdef MUL_ARBITER_HI_EN
    assign resp_hi = prod[PW-1:WIDTH];
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of outstanding multiplies.
module tb_mul_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     resp_valid;
    logic [W-1:0]     resp_data;
    logic [N-1:0]     busy;
`ifdef MUL_ARBITER_HI_EN
    logic [W-1:0]     resp_hi;
`endif

    mul_arbiter #(
        .N_REQ     (N),
        .MUL_LEVEL (3),
        .WIDTH     (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
`ifdef MUL_ARBITER_HI_EN
        .resp_hi    (resp_hi),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          id;
        logic [63:0] prod;
    } pend_t;

    pend_t       pq[$];
    logic [N-1:0] m_busy;
    int          m_ptr;
    bit          m_known;
    int          cyc;
    int          n_checks;
    int          n_errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // One clock cycle: check outputs against the model, take the edge, advance the model.
    task automatic tick();
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic [63:0]  ep;
        int           g;
        int           j;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (g < 0 && req_valid[j] && !m_busy[j]) g = j;
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        er = '0;
        ep = '0;
        foreach (pq[q]) begin
            if (pq[q].due == cyc) begin
                er[pq[q].id] = 1'b1;
                ep = pq[q].prod;
            end
        end
        if (m_known) begin
            chk("req_ready", 64'(req_ready), 64'(eg));
            chk("resp_valid", 64'(resp_valid), 64'(er));
            chk("busy", 64'(busy), 64'(m_busy));
            if (er != '0) begin
                chk("resp_data", 64'(resp_data), 64'(ep[31:0]));
`ifdef MUL_ARBITER_HI_EN
                chk("resp_hi", 64'(resp_hi), 64'(ep[63:32]));
`endif
            end
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            m_busy  = '0;
            m_ptr   = 0;
            pq.delete();
            m_known = 1'b1;
        end else if (m_known) begin
            m_busy = m_busy & ~er;
            if (g >= 0) begin
                m_busy[g] = 1'b1;
                m_ptr     = (g + 1) % N;
                pq.push_back('{cyc + LAT, g,
                               {32'b0, req_a[g*W +: W]} * {32'b0, req_b[g*W +: W]}});
            end
            for (int q = pq.size() - 1; q >= 0; q--) begin
                if (pq[q].due <= cyc) pq.delete(q);
            end
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        m_known   = 1'b0;
        m_busy    = '0;
        m_ptr     = 0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);

        // Reset state
        #1;
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_resp_valid", 64'(resp_valid), 64'h0);
        idle(1);

        // Single issue: 7*6 from requester 0, held valid throughout
        set_op(0, 32'd7, 32'd6);
        req_valid = 4'b0001;
        for (int c = 0; c <= 5; c++) begin
            #1;
            if (c == 0) chk("single_ready_c0", 64'(req_ready), 64'h1);
            if (c >= 1 && c <= 4) chk("single_busy", 64'(busy[0]), 64'h1);
            if (c >= 1 && c <= 4) chk("single_not_ready", 64'(req_ready), 64'h0);
            if (c == 4) begin
                chk("single_resp_valid", 64'(resp_valid), 64'h1);
                chk("single_resp_data", 64'(resp_data), 64'd42);
            end
            if (c == 5) begin
                chk("single_ready_c5", 64'(req_ready), 64'h1);
                req_valid = '0;
            end
            tick();
        end
        idle(6);

        // All four requesters from ptr=0
        do_reset(1);
        for (int i = 0; i < N; i++) set_op(i, 32'(i + 1), 32'd10);
        req_valid = 4'b1111;
        for (int c = 0; c <= 8; c++) begin
            #1;
            if (c <= 3) chk("all4_grant", 64'(req_ready), 64'(1 << c));
            if (c >= 4 && c <= 7) begin
                chk("all4_resp_valid", 64'(resp_valid), 64'(1 << (c - 4)));
                chk("all4_resp_data", 64'(resp_data), 64'(10 * (c - 3)));
            end
            if (c == 3) begin
                tick();
                req_valid = '0;
            end else begin
                tick();
            end
        end
        idle(4);

        // Wrap fairness: move ptr to 3, then 1001 grants 3 then 0, leaving ptr at 1
        set_op(2, 32'd3, 32'd3);
        req_valid = 4'b0100;
        tick();
        idle(6);
        set_op(0, 32'd5, 32'd5);
        set_op(3, 32'd9, 32'd9);
        req_valid = 4'b1001;
        #1;
        chk("wrap_first", 64'(req_ready), 64'h8);
        tick();
        #1;
        chk("wrap_second", 64'(req_ready), 64'h1);
        tick();
        idle(6);
        set_op(1, 32'd2, 32'd2);
        req_valid = 4'b0011;
        #1;
        chk("wrap_ptr_is_1", 64'(req_ready), 64'h2);
        tick();
        idle(6);

        // Overflow: all-ones squared
        set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        for (int c = 1; c <= LAT; c++) begin
            #1;
            if (c == LAT) begin
                chk("ovf_resp_valid", 64'(resp_valid), 64'h2);
                chk("ovf_resp_data", 64'(resp_data), 64'h1);
`ifdef MUL_ARBITER_HI_EN
                chk("ovf_resp_hi", 64'(resp_hi), 64'hFFFF_FFFE);
`endif
            end
            tick();
        end
        idle(2);

        // Reset mid-flight: in-flight results must never appear
        set_op(1, 32'd11, 32'd3);
        set_op(2, 32'd12, 32'd3);
        req_valid = 4'b0110;
        tick();
        tick();
        req_valid = '0;
        tick();
        do_reset(1);
        #1;
        chk("midrst_busy", 64'(busy), 64'h0);
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("midrst_no_resp", 64'(resp_valid), 64'h0);
            tick();
        end
        req_valid = 4'b1111;
        #1;
        chk("midrst_ptr_is_0", 64'(req_ready), 64'h1);
        req_valid = '0;
        tick();

        // Same-cycle response and grant
        do_reset(1);
        set_op(0, 32'd4, 32'd4);
        set_op(2, 32'd8, 32'd8);
        req_valid = 4'b0001;
        for (int c = 0; c <= 5; c++) begin
            if (c == 4) req_valid = 4'b0101;
            #1;
            if (c == 4) begin
                chk("same_resp", 64'(resp_valid), 64'h1);
                chk("same_grant2", 64'(req_ready), 64'h4);
            end
            if (c == 5) chk("same_regrant0", 64'(req_ready), 64'h1);
            if (c >= 1 && c <= 3) chk("same_hold_off", 64'(req_ready), 64'h0);
            tick();
            if (c == 4) req_valid = 4'b0001;
        end
        idle(8);

        // Random traffic against the model, with rare resets
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                set_op(i, $urandom(), ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom());
            end
            rst = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        rst = 1'b1;
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
